// File: rtl/demux16to1_deser.sv
// Serial-to-parallel capture of a 16:1 mux stream into four nibbles.
// Optional even-parity bit after the data: define DEMUX16_PARITY_EN.
module demux16to1_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [3:0] sel,
  output logic       busy,
  output logic       valid,
  output logic       parity_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR,
    DONE
  } state_t;

  localparam logic [3:0] SEL_FIRST = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] SEL_LAST  = MSB_FIRST ? 4'd0  : 4'd15;
  localparam logic [3:0] SEL_STEP  = MSB_FIRST ? 4'hf  : 4'd1;

  state_t      state;
  state_t      state_n;
  logic [15:0] shadow;
`ifdef DEMUX16_PARITY_EN
  logic        pbit;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start && !abort)
          state_n = SHIFT;
      end
      SHIFT: begin
        if (abort)
          state_n = IDLE;
        else if (sel == SEL_LAST)
`ifdef DEMUX16_PARITY_EN
          state_n = PAR;
`else
          state_n = DONE;
`endif
      end
      PAR: begin
        state_n = abort ? IDLE : DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == SHIFT) || (state == PAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      sel        <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
`ifdef DEMUX16_PARITY_EN
      pbit       <= 1'b0;
`endif
    end else begin
      state <= state_n;
      valid <= 1'b0;
      if (state == IDLE && state_n == SHIFT)
        sel <= SEL_FIRST;
      // an aborted cycle neither captures nor advances sel
      if (state == SHIFT && !abort) begin
        shadow[sel] <= din;
        sel         <= sel + SEL_STEP;
      end
`ifdef DEMUX16_PARITY_EN
      if (state == PAR && !abort)
        pbit <= din;
`endif
      if (state == DONE) begin
        a     <= shadow[3:0];
        b     <= shadow[7:4];
        c     <= shadow[11:8];
        d     <= shadow[15:12];
        valid <= 1'b1;
`ifdef DEMUX16_PARITY_EN
        parity_err <= ^shadow ^ pbit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_demux16to1_deser.sv
// Bench: LSB-first and MSB-first instances share one stimulus stream
// and are compared every cycle against a frame-level reference model.
module tb_demux16to1_deser;

`ifdef DEMUX16_PARITY_EN
  localparam int LEN = 17;
  localparam bit PEN = 1'b1;
`else
  localparam int LEN = 16;
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [3:0] a0, b0, c0, d0, sel0;
  logic [3:0] a1, b1, c1, d1, sel1;
  logic busy0, valid0, perr0;
  logic busy1, valid1, perr1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_cyc = 0;
  int v_cyc = 0;
  int vcnt0 = 0;
  int vcnt1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  demux16to1_deser #(.MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .din(din), .start(start), .abort(abort),
    .a(a0), .b(b0), .c(c0), .d(d0), .sel(sel0),
    .busy(busy0), .valid(valid0), .parity_err(perr0)
  );

  demux16to1_deser #(.MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .din(din), .start(start), .abort(abort),
    .a(a1), .b(b1), .c(c1), .d(d1), .sel(sel1),
    .busy(busy1), .valid(valid1), .parity_err(perr1)
  );

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t counts edges since the accepted start.
  // Bits arrive at t=1..16, optional parity at t=17, publish at LEN+1.
  logic        m_act;
  int          m_t;
  logic [15:0] m_bits;
  logic        m_par;
  logic [15:0] m_w0, m_w1;
  logic        m_valid, m_perr;
  logic [3:0]  m_sel0, m_sel1;

  always @(posedge clk or posedge rst) begin : model
    int nt;
    if (rst) begin
      m_act <= 1'b0; m_t <= 0; m_bits <= '0; m_par <= 1'b0;
      m_w0 <= '0; m_w1 <= '0; m_valid <= 1'b0; m_perr <= 1'b0;
      m_sel0 <= '0; m_sel1 <= '0;
    end else begin
      m_valid <= 1'b0;
      if (m_act) begin
        nt = m_t + 1;
        if (abort && nt <= LEN) begin
          m_act <= 1'b0;
        end else begin
          m_t <= nt;
          if (nt <= 16) begin
            m_bits[nt-1] <= din;
            m_sel0 <= 4'(nt);
            m_sel1 <= 4'(15 - nt);
          end
          if (PEN && nt == 17) m_par <= din;
          if (nt == LEN + 1) begin
            m_w0    <= m_bits;
            m_w1    <= rev16(m_bits);
            m_valid <= 1'b1;
            m_perr  <= PEN ? (^m_bits ^ m_par) : 1'b0;
            m_act   <= 1'b0;
          end
        end
      end else if (start && !abort) begin
        m_act  <= 1'b1;
        m_t    <= 0;
        m_sel0 <= 4'd0;
        m_sel1 <= 4'd15;
      end
    end
  end

  always @(negedge clk) begin
    chk("u0.word", {d0, c0, b0, a0}, m_w0);
    chk("u1.word", {d1, c1, b1, a1}, m_w1);
    chk("u0.sel", sel0, m_sel0);
    chk("u1.sel", sel1, m_sel1);
    chk("u0.busy", busy0, m_act && m_t < LEN);
    chk("u1.busy", busy1, m_act && m_t < LEN);
    chk("u0.valid", valid0, m_valid);
    chk("u1.valid", valid1, m_valid);
    chk("u0.perr", perr0, m_perr);
    chk("u1.perr", perr1, m_perr);
    if (valid0) begin
      vcnt0++;
      v_cyc = cyc;
    end
    if (valid1) vcnt1++;
  end

  task automatic frame(input logic [15:0] seq, input logic pbit,
                       input int abort_k, input int mid_k);
    @(negedge clk);
    start = 1'b1;
    st_cyc = cyc + 1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start = (k == mid_k);
      abort = (k == abort_k);
      din = seq[k];
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    din = pbit;
    repeat (4) @(negedge clk);
    din = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".u0.word"}, {d0, c0, b0, a0}, 16'h0000);
    chk({tag, ".u1.word"}, {d1, c1, b1, a1}, 16'h0000);
    chk({tag, ".u0.sel"}, sel0, 4'd0);
    chk({tag, ".u1.sel"}, sel1, 4'd0);
    chk({tag, ".busy"}, {busy0, busy1}, 2'b00);
    chk({tag, ".valid"}, {valid0, valid1}, 2'b00);
    chk({tag, ".perr"}, {perr0, perr1}, 2'b00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("idle");

    // start and abort together in IDLE: nothing happens
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort.busy", {busy0, busy1}, 2'b00);

    // LSB-first word 0111_0011_0001_0000, index 0 first
    frame(16'h7310, 1'b0, -1, -1);
    chk("f1.model", m_w0, 16'h7310);
    chk("f1.u0", {d0, c0, b0, a0}, 16'h7310);
    chk("f1.u1", {d1, c1, b1, a1}, 16'h08CE);
    chk("f1.latency", v_cyc - st_cyc, LEN + 1);
    chk("f1.vcnt", vcnt0, 1);

    // MSB-first word 1111_1110_1001_0010, index 15 first
    frame(rev16(16'hFE92), 1'b0, -1, -1);
    chk("f2.model", m_w1, 16'hFE92);
    chk("f2.u1", {d1, c1, b1, a1}, 16'hFE92);
    chk("f2.u0", {d0, c0, b0, a0}, 16'h497F);
    chk("f2.u0sel", sel0, 4'd0);
    chk("f2.u1sel", sel1, 4'd15);
    chk("f2.latency", v_cyc - st_cyc, LEN + 1);

    // abort on 8th SHIFT cycle, stray start pulse on 4th
    frame(16'hAAAA, 1'b1, 7, 3);
    chk("abort.u0", {d0, c0, b0, a0}, 16'h497F);
    chk("abort.u1", {d1, c1, b1, a1}, 16'hFE92);
    chk("abort.vcnt0", vcnt0, 2);
    chk("abort.vcnt1", vcnt1, 2);

    // async reset between edges during the 5th SHIFT cycle
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      din = 1'b1;
    end
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    din = 1'b0;
    @(negedge clk);

    frame(16'h8738, 1'b0, -1, -1);
    chk("f3.model", m_w0, 16'h8738);
    chk("f3.u0", {d0, c0, b0, a0}, 16'h8738);
    chk("f3.u1", {d1, c1, b1, a1}, 16'h1CE1);
    chk("f3.vcnt", vcnt0, 3);

`ifdef DEMUX16_PARITY_EN
    frame(16'h0001, 1'b1, -1, -1);
    chk("par1.u0", perr0, 1'b0);
    chk("par1.u1", perr1, 1'b0);
    chk("par1.latency", v_cyc - st_cyc, 18);
    frame(16'h0001, 1'b0, -1, -1);
    chk("par0.u0", perr0, 1'b1);
    chk("par0.u1", perr1, 1'b1);
    chk("par0.latency", v_cyc - st_cyc, 18);
`else
    frame(16'h0001, 1'b1, -1, -1);
    chk("nopar.perr", {perr0, perr1}, 2'b00);
    chk("nopar.u0", {d0, c0, b0, a0}, 16'h0001);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
